dac8_stream_driver: RTL and testbench

- Output stage between the audio/signal generator logic inside M_main and the 8-bit parallel DAC pins.
- Accepts 8-bit samples over a valid/ready handshake into a small FIFO and plays them out at a fixed rate of one sample per DIV clocks.
- Generates the DAC_CLK strobe with data stable around its rising edge.
- Flags underruns and fills starved sample slots by repeating the previous sample.

---
 rtl/dac8_stream_driver.sv | 86 ++++++++
 tb/tb_dac8_stream_driver.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac8_stream_driver.sv
// 8-bit DAC output stage: sample FIFO drained at one sample per DIV clocks, with DAC_CLK strobe and underrun flag.
// Optional DAC8_SIGNED_INPUT_EN: treat in_sample as two's complement and convert to offset binary on pop.
module dac8_stream_driver #(
    parameter int DIV   = 4,
    parameter int DEPTH = 8,
    parameter int LW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    in_sample,
    input  logic          in_valid,
    output logic          out_ready,
    input  logic          in_clr_underrun,
    output logic [7:0]    out_dac_data,
    output logic          out_dac_clk,
    output logic          out_underrun,
    output logic [LW-1:0] out_level
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(DIV / 2);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LV_ONE  = LW'(1);
    localparam logic [LW-1:0] LV_FULL = LW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] phase, phase_nxt;
    logic          tick, push, pop;
    logic [7:0]    head;

    // Ready depends on the level register only, never on in_valid.
    assign out_ready = (out_level < LV_FULL);

    always_comb begin
        tick      = (phase == PH_LAST);
        phase_nxt = tick ? '0 : phase + PH_ONE;
        push      = in_valid && out_ready;
        pop       = tick && (out_level != '0);
`ifdef DAC8_SIGNED_INPUT_EN
        head      = {~mem[rd_ptr][7], mem[rd_ptr][6:0]};
`else
        head      = mem[rd_ptr];
`endif
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= in_sample;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase        <= '0;
            out_dac_clk  <= 1'b0;
            out_dac_data <= 8'h80;
            out_underrun <= 1'b0;
            out_level    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            phase       <= phase_nxt;
            // Strobe rises DIV/2 cycles after each data update, centring the data window.
            out_dac_clk <= (phase_nxt >= PH_HALF);
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                out_dac_data <= head;
                rd_ptr       <= rd_ptr + PTR_ONE;
            end
            if (tick && !pop)
                out_underrun <= 1'b1;
            else if (in_clr_underrun)
                out_underrun <= 1'b0;
            case ({push, pop})
                2'b10:   out_level <= out_level + LV_ONE;
                2'b01:   out_level <= out_level - LV_ONE;
                default: out_level <= out_level;
            endcase
        end
    end

endmodule

// File: tb/tb_dac8_stream_driver.sv
// Scoreboard bench for dac8_stream_driver: queue model of FIFO, phase, strobe and underrun flag.
// Define DAC8_SIGNED_INPUT_EN for both DUT and bench to exercise the signed mapping.
module tb_dac8_stream_driver;

    localparam int DIV   = 4;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    in_sample = 8'h00;
    logic          in_valid = 1'b0;
    logic          out_ready;
    logic          in_clr_underrun = 1'b0;
    logic [7:0]    out_dac_data;
    logic          out_dac_clk;
    logic          out_underrun;
    logic [LW-1:0] out_level;

    dac8_stream_driver #(.DIV(DIV), .DEPTH(DEPTH), .LW(LW)) dut (
        .clock(clock), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
        .out_ready(out_ready), .in_clr_underrun(in_clr_underrun),
        .out_dac_data(out_dac_data), .out_dac_clk(out_dac_clk),
        .out_underrun(out_underrun), .out_level(out_level)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_data  = 8'h80;
    int         m_phase = 0;
    logic       m_under = 1'b0;
    logic       m_pushed;
    logic       m_popped;

    function automatic logic [7:0] conv(input logic [7:0] s);
`ifdef DAC8_SIGNED_INPUT_EN
        return s ^ 8'h80;
`else
        return s;
`endif
    endfunction

    function automatic logic [14:0] obs();
        return {out_dac_data, out_dac_clk, out_underrun, out_level, out_ready};
    endfunction

    function automatic logic [14:0] expv();
        return {m_data, (m_phase >= DIV/2), m_under, LW'(q.size()), (q.size() < DEPTH)};
    endfunction

    // Advance one clock; inputs are sampled from their current values, model updated after the edge.
    task automatic step();
        logic tick, pop, push;
        push = in_valid && (q.size() < DEPTH);
        tick = (m_phase == DIV-1);
        pop  = tick && (q.size() > 0);
        @(posedge clock); #1;
        m_pushed = 1'b0;
        m_popped = 1'b0;
        if (reset) begin
            q.delete();
            m_phase = 0;
            m_data  = 8'h80;
            m_under = 1'b0;
        end else begin
            if (pop) begin
                m_data   = conv(q.pop_front());
                m_popped = 1'b1;
            end
            if (push) begin
                q.push_back(in_sample);
                m_pushed = 1'b1;
            end
            if (tick && !pop) m_under = 1'b1;
            else if (in_clr_underrun) m_under = 1'b0;
            m_phase = tick ? 0 : m_phase + 1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_clr_underrun = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (obs() !== {8'h80, 1'b0, 1'b0, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", obs(), {8'h80, 1'b0, 1'b0, 4'd0, 1'b1});
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_vec++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL idle cyc %0d: got %h want %h", i, obs(), expv());
            end
            if (i == 3) begin
                n_vec++;
                if (out_underrun !== 1'b1) begin
                    n_err++;
                    $display("FAIL idle_first_tick_underrun: got %b want 1", out_underrun);
                end
            end
        end
    endtask

    task automatic test_stream();
        logic [7:0] vals [3] = '{8'h10, 8'h20, 8'h30};
        int maxlvl = 0;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            in_valid  = (i < 3);
            in_sample = (i < 3) ? vals[i] : 8'h00;
            step();
            if (int'(out_level) > maxlvl) maxlvl = int'(out_level);
            n_vec++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL stream cyc %0d: got %h want %h", i, obs(), expv());
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (maxlvl != 3) begin
            n_err++;
            $display("FAIL stream_max_level: got %0d want 3", maxlvl);
        end
        n_vec++;
        if ({out_dac_data, out_underrun} !== {8'h30, 1'b1}) begin
            n_err++;
            $display("FAIL stream_hold: got %h/%b want 30/1", out_dac_data, out_underrun);
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0, gaps = 0, seen_full = 0;
        logic [7:0] last = 8'h00;
        do_reset();
        in_valid  = 1'b1;
        in_sample = 8'h01;
        for (int i = 0; i < 64; i++) begin
            if (i >= 20 && i < 60 && out_ready) accepts++;
            step();
            if (m_pushed) in_sample = in_sample + 8'h01;
            if (out_level == 4'd8 && out_ready == 1'b0) seen_full = 1;
            if (m_phase == 0 && i >= 3) begin
                if (out_dac_data !== last + 8'h01) gaps++;
                last = out_dac_data;
            end
            n_vec++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL b2b cyc %0d: got %h want %h", i, obs(), expv());
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (seen_full != 1) begin
            n_err++;
            $display("FAIL b2b_full_seen: got %0d want 1", seen_full);
        end
        n_vec++;
        if (accepts != 10) begin
            n_err++;
            $display("FAIL b2b_accepts_per_tick: got %0d want 10", accepts);
        end
        n_vec++;
        if (gaps != 0) begin
            n_err++;
            $display("FAIL b2b_sequence_gaps: got %0d want 0", gaps);
        end
    endtask

    task automatic test_clr_underrun();
        do_reset();
        in_clr_underrun = 1'b1;
        for (int i = 0; i < 4; i++) step();
        in_clr_underrun = 1'b0;
        n_vec++;
        if (out_underrun !== 1'b1) begin
            n_err++;
            $display("FAIL clr_vs_set: got %b want 1", out_underrun);
        end
        in_valid = 1'b1;
        in_sample = 8'hA5; step();
        in_sample = 8'h5A; step();
        in_valid = 1'b0;
        in_clr_underrun = 1'b1;
        step();
        in_clr_underrun = 1'b0;
        n_vec++;
        if ({out_underrun, (out_level != 0)} !== 2'b01) begin
            n_err++;
            $display("FAIL clr_nontick: got under=%b level=%0d want 0/>0", out_underrun, out_level);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            n_vec++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL clr cyc %0d: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_reset_mid();
        int leaks = 0;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_sample = 8'hC0 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        n_vec++;
        if (out_level !== 4'd5) begin
            n_err++;
            $display("FAIL rstmid_queued: got %0d want 5", out_level);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++;
        if ({out_level, out_dac_data, out_ready} !== {4'd0, 8'h80, 1'b1}) begin
            n_err++;
            $display("FAIL rstmid_state: got %h want %h", {out_level, out_dac_data, out_ready}, {4'd0, 8'h80, 1'b1});
        end
        for (int i = 0; i < 24; i++) begin
            step();
            if (out_dac_data !== 8'h80) leaks++;
            n_vec++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL rstmid cyc %0d: got %h want %h", i, obs(), expv());
            end
        end
        n_vec++;
        if (leaks != 0) begin
            n_err++;
            $display("FAIL rstmid_old_samples: got %0d want 0", leaks);
        end
    endtask

    task automatic test_signed_map();
        logic [7:0] ins  [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
`ifdef DAC8_SIGNED_INPUT_EN
        logic [7:0] outs [4] = '{8'h80, 8'hFF, 8'h00, 8'h7F};
`else
        logic [7:0] outs [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
`endif
        int k = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            in_valid  = (i < 4);
            in_sample = (i < 4) ? ins[i] : 8'h00;
            step();
            if (m_popped && k < 4) begin
                n_vec++;
                if (out_dac_data !== outs[k]) begin
                    n_err++;
                    $display("FAIL signed_map %0d: got %h want %h", k, out_dac_data, outs[k]);
                end
                k++;
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (k != 4) begin
            n_err++;
            $display("FAIL signed_map_count: got %0d want 4", k);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_clr_underrun();
        test_reset_mid();
        test_signed_map();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
